mux8_rr: RTL and testbench
==========================

// Module: mux8_rr
// PURPOSE
// Collecting counterpart of dmux8: merges eight N-bit source channels into one
// N-bit output stream. Arbitration is round-robin and both sides use a
// valid/ready handshake. The output is registered and tagged with the 3-bit
// source index s, so a downstream dmux8 can route each word back by s.
// PARAMETERS
// N  6  data width of every channel and of the output
// PORTS
// clk      in   1    clock, all state updates on rising edge
// rst      in   1    reset, asynchronous, active-high
// d0..d7   in   N    channel data, sampled only on that channel's accept cycle
// v        in   8    v[i]=1: channel i has a word on d<i>
// rdy      out  8    rdy[i]=1: channel i's word is accepted this cycle (one-hot or 0)
// en       in   8    en[i]=0 masks channel i out of arbitration
// y        out  N    registered output data
// s        out  3    registered source index of y
// y_valid  out  1    y/s hold a word
// y_ready  in   1    downstream accepts y/s this cycle
// BEHAVIOUR
// - State: output register {y,s,y_valid}; 3-bit round-robin pointer ptr (next priority).
// - Reset (async, immediate): y=0, s=0, y_valid=0, ptr=0, rdy=0 while rst=1.
// - free = !y_valid | y_ready (combinational; output stage can take a word this cycle).
// - req[i] = v[i] & en[i]. grant = first set req scanning ptr, ptr+1, ..., ptr+7 mod 8.
// - rdy = free ? onehot(grant) : 0; rdy is 0 when no req. rdy never depends on rdy.
// - Edge, free & some req (winner g): y<=d<g>, s<=g, y_valid<=1, ptr<=(g+1) mod 8.
// - Edge, free & no req: y_valid<=0; y, s, ptr hold.
// - Edge, !free (y_valid=1, y_ready=0): y, s, y_valid, ptr hold; all rdy=0.
// - Latency 1 cycle d->y; throughput 1 word/cycle with y_ready held 1.
// - Simultaneous drain+load: when y_valid & y_ready & req, new word replaces old
//   on the same edge with no bubble.
// - Wrap-around: grant 7 -> ptr=0; scan wraps mod 8. A lone requester wins every
//   cycle regardless of ptr.
// - Fairness: each continuously requesting channel is granted within 8 accepts.
// - en change takes effect the same cycle; masked channel never sees rdy=1.
// - y/s stable while y_valid=1 & y_ready=0 (no change under backpressure).
// - Reset mid-transfer drops the held word; first grant after reset starts at ptr=0.
// TESTING
// T1 reset: rst=1 with v=8'hFF -> rdy=0, y_valid=0, y=0, s=0; release, next edge
//    with y_ready=1 -> s=0, y=d0.
// T2 single channel: v=8'h20, d5=6'h2A, y_ready=1 -> rdy=8'h20, next cycle
//    y=6'h2A, s=5, y_valid=1; repeats each cycle.
// T3 round-robin: v=8'hFF, y_ready=1, d<i>=i -> s sequence 0,1,..,7,0,1 one per
//    cycle; rdy one-hot matching.
// T4 backpressure: y_valid=1, s=3, y_ready=0 for 4 cycles -> y,s constant, rdy=0;
//    y_ready=1 -> next word from channel 4 loaded same edge.
// T5 mask+wrap: ptr=7, v=8'h81, en=8'h7F -> s=0 only; en=8'hFF -> alternates 7,0.
// T6 reset mid-op: rst pulsed while y_valid=1, s=6 -> y_valid=0 immediately;
//    after release with v=8'hC1 -> s=0 first.

Source files
------------

// File: rtl/mux8_rr.sv
// Eight-channel round-robin collector: merges valid/ready sources into one
// registered output stream tagged with the winning source index.
module mux8_rr #(
    parameter int unsigned N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    input  logic [N-1:0] d4,
    input  logic [N-1:0] d5,
    input  logic [N-1:0] d6,
    input  logic [N-1:0] d7,
    input  logic [7:0]   v,
    output logic [7:0]   rdy,
    input  logic [7:0]   en,
    output logic [N-1:0] y,
    output logic [2:0]   s,
    output logic         y_valid,
    input  logic         y_ready
);

    localparam int unsigned NCH = 8;
    localparam int unsigned IW  = 3;

    logic [N-1:0]  d_arr [NCH];
    logic [N-1:0]  y_q, y_d;
    logic [IW-1:0] s_q, s_d;
    logic          yv_q, yv_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [NCH-1:0] req;
    logic [IW-1:0] grant;
    logic [IW-1:0] idx;
    logic          found;
    logic          free;

    assign d_arr[0] = d0;
    assign d_arr[1] = d1;
    assign d_arr[2] = d2;
    assign d_arr[3] = d3;
    assign d_arr[4] = d4;
    assign d_arr[5] = d5;
    assign d_arr[6] = d6;
    assign d_arr[7] = d7;

    // Priority scan starting at ptr_q, wrapping through the 3-bit index.
    always_comb begin
        req   = v & en;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            idx = ptr_q + IW'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign free = !yv_q || y_ready;

    always_comb begin
        rdy = '0;
        if (!rst && free && found) begin
            rdy = NCH'(1) << grant;
        end
    end

    always_comb begin
        y_d   = y_q;
        s_d   = s_q;
        yv_d  = yv_q;
        ptr_d = ptr_q;
        if (free) begin
            if (found) begin
                y_d   = d_arr[grant];
                s_d   = grant;
                yv_d  = 1'b1;
                ptr_d = grant + IW'(1);
            end else begin
                yv_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= '0;
            s_q   <= '0;
            yv_q  <= 1'b0;
            ptr_q <= '0;
        end else begin
            y_q   <= y_d;
            s_q   <= s_d;
            yv_q  <= yv_d;
            ptr_q <= ptr_d;
        end
    end

    assign y       = y_q;
    assign s       = s_q;
    assign y_valid = yv_q;

endmodule

// File: tb/tb_mux8_rr.sv
// Self-checking bench for mux8_rr: directed scenarios plus random traffic,
// all scored against a behavioural round-robin model.
module tb_mux8_rr;

    localparam int unsigned N = 6;

    logic         clk;
    logic         rst;
    logic [N-1:0] d [8];
    logic [7:0]   v;
    logic [7:0]   rdy;
    logic [7:0]   en;
    logic [N-1:0] y;
    logic [2:0]   s;
    logic         y_valid;
    logic         y_ready;

    int n_vec;
    int n_miss;

    // model state
    int           m_ptr;
    logic [N-1:0] m_y;
    int           m_s;
    bit           m_yv;

    mux8_rr #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .v(v), .rdy(rdy), .en(en),
        .y(y), .s(s), .y_valid(y_valid), .y_ready(y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_y   = '0;
        m_s   = 0;
        m_yv  = 0;
    endtask

    // Winner among enabled requesters, searching from the model pointer; -1 if none.
    function automatic int model_winner();
        for (int k = 0; k < 8; k++) begin
            int c;
            c = (m_ptr + k) % 8;
            if (v[c] && en[c]) return c;
        end
        return -1;
    endfunction

    // One clock: check rdy before the edge, advance the model, check outputs after.
    task automatic cycle(input string tag);
        int  w;
        bit  fr;
        logic [7:0] exp_rdy;
        #1;
        w  = model_winner();
        fr = !m_yv || y_ready;
        exp_rdy = 8'h00;
        if (!rst && fr && w >= 0) exp_rdy = 8'h01 << w;
        check({tag, "_rdy"}, 32'(rdy), 32'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (fr) begin
            if (w >= 0) begin
                m_y   = d[w];
                m_s   = w;
                m_yv  = 1;
                m_ptr = (w + 1) % 8;
            end else begin
                m_yv = 0;
            end
        end
        #1;
        check({tag, "_yv"}, 32'(y_valid), 32'(m_yv));
        if (m_yv || rst) begin
            check({tag, "_y"}, 32'(y), 32'(m_y));
            check({tag, "_s"}, 32'(s), 32'(m_s));
        end
    endtask

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        rst     = 1'b1;
        v       = 8'hFF;
        en      = 8'hFF;
        y_ready = 1'b1;
        for (int i = 0; i < 8; i++) d[i] = N'(i + 8);
        model_reset();

        // T1: reset holds everything low even with all channels requesting
        #2;
        check("t1_rdy", 32'(rdy), 32'h00);
        check("t1_yv", 32'(y_valid), 32'h0);
        check("t1_y", 32'(y), 32'h0);
        check("t1_s", 32'(s), 32'h0);
        @(posedge clk);
        #1;
        check("t1_rdy_hold", 32'(rdy), 32'h00);
        rst = 1'b0;
        cycle("t1");
        check("t1_first_s", 32'(s), 32'd0);
        check("t1_first_y", 32'(y), 32'd8);

        // T2: lone requester wins every cycle
        v = 8'h20;
        d[5] = 6'h2A;
        for (int i = 0; i < 3; i++) begin
            cycle("t2");
            check("t2_s", 32'(s), 32'd5);
            check("t2_y", 32'(y), 32'h2A);
        end

        // T3: full round-robin rotation
        for (int i = 0; i < 8; i++) d[i] = N'(i);
        model_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        v = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            cycle("t3");
            check("t3_seq", 32'(s), 32'(i % 8));
        end

        // T4: backpressure holds y/s, then release loads channel 4 same edge
        v = 8'h08;
        cycle("t4_load");
        check("t4_s3", 32'(s), 32'd3);
        v = 8'hFF;
        y_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle("t4_bp");
            check("t4_bp_s", 32'(s), 32'd3);
            check("t4_bp_rdy", 32'(rdy), 32'h00);
        end
        y_ready = 1'b1;
        cycle("t4_rel");
        check("t4_rel_s", 32'(s), 32'd4);

        // T5: masked channel 7 around the wrap point
        v = 8'h40;
        cycle("t5_pre");
        v  = 8'h81;
        en = 8'h7F;
        for (int i = 0; i < 3; i++) begin
            cycle("t5_mask");
            check("t5_mask_s", 32'(s), 32'd0);
        end
        en = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            cycle("t5_alt");
            check("t5_alt_s", 32'(s), (i % 2 == 0) ? 32'd7 : 32'd0);
        end

        // T6: asynchronous reset while holding a word from channel 6
        v = 8'h40;
        cycle("t6_pre");
        y_ready = 1'b0;
        cycle("t6_hold");
        check("t6_s6", 32'(s), 32'd6);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_yv", 32'(y_valid), 32'h0);
        check("t6_async_rdy", 32'(rdy), 32'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        y_ready = 1'b1;
        v = 8'hC1;
        cycle("t6_after");
        check("t6_first_s", 32'(s), 32'd0);

        // Random traffic with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 8; c++) d[c] = N'($urandom);
            v       = 8'($urandom);
            en      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            y_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            cycle("rnd");
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
